apb_mem_slave: RTL and testbench

Parametrised APB slave exposing a word-addressed register/memory array, with configurable wait states, byte-lane write strobes and error response on out-of-range accesses. Successor to the fixed 32x32 APB memory slave: same P_* bus, but a registered transaction capture and a defined completion cycle. Sits behind the APB bridge as a generic scratchpad/config target.

---
 rtl/apb_mem_slave_pkg.sv | 27 ++
 rtl/apb_mem_slave_if.sv | 33 +++
 rtl/apb_mem_slave_array.sv | 58 +++++
 rtl/apb_mem_slave.sv | 129 ++++++++++++
 tb/tb_apb_mem_slave.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_mem_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared types and defaults for the APB memory slave slice.
//             Provides the transfer state enum, bus width defaults and a
//             helper that derives the strobe width from a data width.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    // Two states only; the remaining encodings of the 2-bit field are spare
    // and are treated as IDLE by the slave FSM.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01
    } apb_state_e;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_mem_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_slave_if
//  Purpose  : APB bus bundle between a requester and the memory slave.
//  Ports    : P_addr/P_selx/P_enable/P_write/P_wdata/P_strb  (master -> slave)
//             P_ready/P_slverr/P_rdata                       (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   P_addr;
    logic                P_selx;
    logic                P_enable;
    logic                P_write;
    logic [DATA_W-1:0]   P_wdata;
    logic [DATA_W/8-1:0] P_strb;
    logic                P_ready;
    logic                P_slverr;
    logic [DATA_W-1:0]   P_rdata;

    modport master (
        output P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
        input  P_ready, P_slverr, P_rdata
    );

    modport slave (
        input  P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
        output P_ready, P_slverr, P_rdata
    );
endinterface : apb_mem_slave_if
`default_nettype wire

// File: rtl/apb_mem_slave_array.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_array
//  Purpose  : DEPTH x DATA_W storage with per-byte write enables, synchronous
//             clear of every word, and a combinational read port.
//  Ports    : clk, rst          - clock, synchronous active-high clear
//             i_we              - commit a write this edge
//             i_idx             - word index for both read and write
//             i_wdata, i_strb   - write data and byte-lane enables
//             o_rdata           - word at i_idx (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_we,
    input  wire logic [IDX_W-1:0]         i_idx,
    input  wire logic [DATA_W-1:0]        i_wdata,
    input  wire logic [strb_w(DATA_W)-1:0] i_strb,
    output logic      [DATA_W-1:0]        o_rdata
);

    localparam int STRB_W = strb_w(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i_strb[i]) begin
                    mem_d[i_idx][i*8 +: 8] = i_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_rdata = mem_q[i_idx];

endmodule : apb_mem_array
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_slave
//  Purpose  : APB slave exposing a word-addressed memory with configurable
//             wait states, byte-lane strobes and SLVERR on out-of-range words.
//             The setup phase is registered; the access phase completes in its
//             (1+WAIT_CYCLES)-th cycle.
//  Ports    : P_clk, P_rst - clock, synchronous active-high reset
//             bus          - APB slave modport (addr/selx/enable/write/wdata/
//                            strb in, ready/slverr/rdata out)
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = APB_DATA_W,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  wire logic       P_clk,
    input  wire logic       P_rst,
    apb_mem_slave_if.slave  bus
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = 4;

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);

    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              write_q,    write_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [STRB_W-1:0] strb_q,     strb_d;

    logic              access_ok;
    logic              done;
    logic              err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Full-width compare so high address bits never alias into the array.
    assign err       = (addr_q >= DEPTH_A);
    assign access_ok = (state_q == S_ACCESS) && bus.P_selx && bus.P_enable;
    assign done      = access_ok && (wait_cnt_q == WAIT_LAST);
    assign mem_we    = done && write_q && !err;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;

        case (state_q)
            S_ACCESS: begin
                if (bus.P_selx && bus.P_enable) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Master abandoned the transfer: drop it without a write.
                    state_d = S_IDLE;
                end
            end
            default: begin
                // IDLE and spare encodings. ENABLE without a prior setup
                // phase is a protocol violation and is ignored.
                state_d = S_IDLE;
                if (bus.P_selx && !bus.P_enable) begin
                    addr_d     = bus.P_addr;
                    write_d    = bus.P_write;
                    wdata_d    = bus.P_wdata;
                    strb_d     = bus.P_strb;
                    wait_cnt_d = '0;
                    state_d    = S_ACCESS;
                end
            end
        endcase
    end

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
        end
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (P_clk),
        .rst     (P_rst),
        .i_we    (mem_we),
        .i_idx   (addr_q[IDX_W-1:0]),
        .i_wdata (wdata_q),
        .i_strb  (strb_q),
        .o_rdata (mem_rdata)
    );

    assign bus.P_ready  = done;
    assign bus.P_slverr = done && err;
    assign bus.P_rdata  = (done && !write_q && !err) ? mem_rdata : '0;

endmodule : apb_mem_slave
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_mem_slave
//  Purpose  : Self-checking bench for apb_mem_slave. Three instances with
//             WAIT_CYCLES = 0, 3, 2 share one stimulus bus; dut_sel routes
//             select/enable to one of them and muxes its response back.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        selx = 1'b0;
    logic        enable = 1'b0;
    logic        write = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  strb = '0;
    int          dut_sel = 0;

    logic        rdy;
    logic        slverr;
    logic [31:0] rdata;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] model [3][32];
    logic [31:0] last_rdata;
    int          waits_of [3] = '{0, 3, 2};

    always #5 clk = ~clk;

    apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

    assign if0.P_addr = addr;  assign if1.P_addr = addr;  assign if2.P_addr = addr;
    assign if0.P_write = write; assign if1.P_write = write; assign if2.P_write = write;
    assign if0.P_wdata = wdata; assign if1.P_wdata = wdata; assign if2.P_wdata = wdata;
    assign if0.P_strb = strb;  assign if1.P_strb = strb;  assign if2.P_strb = strb;
    assign if0.P_selx = selx && (dut_sel == 0);
    assign if1.P_selx = selx && (dut_sel == 1);
    assign if2.P_selx = selx && (dut_sel == 2);
    assign if0.P_enable = enable && (dut_sel == 0);
    assign if1.P_enable = enable && (dut_sel == 1);
    assign if2.P_enable = enable && (dut_sel == 2);

    always_comb begin
        rdy = if0.P_ready; slverr = if0.P_slverr; rdata = if0.P_rdata;
        if (dut_sel == 1) begin
            rdy = if1.P_ready; slverr = if1.P_slverr; rdata = if1.P_rdata;
        end else if (dut_sel == 2) begin
            rdy = if2.P_ready; slverr = if2.P_slverr; rdata = if2.P_rdata;
        end
    end

    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(0))
        u_dut0 (.P_clk(clk), .P_rst(rst), .bus(if0.slave));
    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(3))
        u_dut1 (.P_clk(clk), .P_rst(rst), .bus(if1.slave));
    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(2))
        u_dut2 (.P_clk(clk), .P_rst(rst), .bus(if2.slave));

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 32; w++)
                model[d][w] = '0;
    endtask

    // Entered at #1 after a rising edge; leaves at #1 after the completion
    // edge with the bus idle, so consecutive calls are back-to-back.
    task automatic xfer(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
        exp_t e;
        exp_t got;
        bit   oor;
        bit   fin;
        int   cyc;
        oor     = (a >= 32);
        e.err   = oor;
        e.rdata = (!w && !oor) ? model[d][a[4:0]] : 32'h0;
        e.waits = waits_of[d];
        sb.push_back(e);
        if (w && !oor)
            for (int i = 0; i < 4; i++)
                if (s[i]) model[d][a[4:0]][i*8 +: 8] = wd[i*8 +: 8];

        dut_sel = d; selx = 1'b1; enable = 1'b0;
        write = w; addr = a; wdata = wd; strb = s;
        @(posedge clk); #1;
        enable = 1'b1;
        addr = $urandom; wdata = $urandom; strb = 4'($urandom);
        cyc = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                fin = 1'b1;
                got = sb.pop_front();
                last_rdata = rdata;
                checks++;
                if (rdata !== got.rdata) begin
                    errors++;
                    $display("FAIL rdata dut%0d addr=%0d: got %h want %h", d, a, rdata, got.rdata);
                end
                checks++;
                if (slverr !== got.err) begin
                    errors++;
                    $display("FAIL slverr dut%0d addr=%0d: got %b want %b", d, a, slverr, got.err);
                end
                checks++;
                if (cyc != got.waits) begin
                    errors++;
                    $display("FAIL latency dut%0d addr=%0d: got %0d want %0d", d, a, cyc, got.waits);
                end
            end else begin
                cyc++;
                if (cyc > 40) begin
                    fin = 1'b1;
                    void'(sb.pop_front());
                    checks++; errors++;
                    $display("FAIL timeout dut%0d addr=%0d: got no ready want ready", d, a);
                end
            end
        end
        @(posedge clk); #1;
        selx = 1'b0; enable = 1'b0;
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if (rdy !== 1'b0 || slverr !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s dut%0d: got rdy=%b err=%b rdata=%h want 0/0/0",
                     name, dut_sel, rdy, slverr, rdata);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            dut_sel = d;
            #1 expect_idle("reset_outputs");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 32'd5, 32'h0, 4'h0);
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL zw_read: got %h want deadbeef", last_rdata);
        end
    endtask

    task automatic test_strobes();
        xfer(0, 1'b1, 32'd3, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 32'd3, 32'hAABBCCDD, 4'h5);
        xfer(0, 1'b1, 32'd3, 32'hFFFFFFFF, 4'h0);
        xfer(0, 1'b0, 32'd3, 32'h0, 4'h0);
        checks++;
        if (last_rdata !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe_merge: got %h want 11bb33dd", last_rdata);
        end
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, 32'd40, 32'h1, 4'hF);
        xfer(0, 1'b0, 32'd40, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h8000_0003, 32'h5A5A5A5A, 4'hF);
        for (int w = 0; w < 32; w++)
            xfer(0, 1'b0, 32'(w), 32'h0, 4'h0);
        xfer(0, 1'b0, 32'd8, 32'h0, 4'h0);
        checks++;
        if (last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_alias: got %h want 00000000", last_rdata);
        end
    endtask

    task automatic test_wait_states();
        xfer(1, 1'b0, 32'd0, 32'h0, 4'h0);
        xfer(1, 1'b1, 32'd31, 32'h0BADF00D, 4'hF);
        xfer(1, 1'b0, 32'd31, 32'h0, 4'h0);
    endtask

    task automatic test_abort();
        dut_sel = 2; selx = 1'b1; enable = 1'b0;
        write = 1'b1; addr = 32'd7; wdata = 32'h0000CAFE; strb = 4'hF;
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk) expect_idle("abort_access");
        @(posedge clk); #1 selx = 1'b0; enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) expect_idle("abort_after");
        end
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'd7, 32'h0, 4'h0);
        checks++;
        if (last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_write: got %h want 00000000", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        xfer(2, 1'b1, 32'd9, 32'h01020304, 4'hF);
        xfer(2, 1'b0, 32'd9, 32'h0, 4'h0);
        xfer(2, 1'b1, 32'd9, 32'hF0F0F0F0, 4'hC);
        xfer(2, 1'b0, 32'd9, 32'h0, 4'h0);
        checks++;
        if (last_rdata !== 32'hF0F00304) begin
            errors++;
            $display("FAIL b2b_read: got %h want f0f00304", last_rdata);
        end
    endtask

    task automatic test_mid_reset();
        dut_sel = 1; selx = 1'b1; enable = 1'b0;
        write = 1'b1; addr = 32'd2; wdata = 32'h12345678; strb = 4'hF;
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        clear_model();
        // Bus still shows an access phase; with no setup the slave must stay quiet.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) expect_idle("reset_mid_xfer");
        end
        @(posedge clk); #1 selx = 1'b0; enable = 1'b0;
        xfer(1, 1'b0, 32'd2, 32'h0, 4'h0);
        // ENABLE without setup on the zero-wait instance.
        dut_sel = 0; selx = 1'b1; enable = 1'b1; write = 1'b0; addr = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) expect_idle("enable_no_setup");
        end
        @(posedge clk); #1 selx = 1'b0; enable = 1'b0;
        xfer(0, 1'b0, 32'd5, 32'h0, 4'h0);
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_zero_wait();
        test_strobes();
        test_out_of_range();
        test_wait_states();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_apb_mem_slave
`default_nettype wire
